// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared memory port between instruction fetch (0)
// and data load/store (1); holds the port for LAT cycles, then pulses done.
`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int WIDTH = 16,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             we0,
    input  logic             req1,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata1,
    input  logic             we1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] rdata,
    output logic             sel,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // count holds the number of BUSY cycles still to go after the current one
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t           state_q, state_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [3:0]       count_q, count_d;
    logic             last_served_q, last_served_d;
    logic             win_s;

    // Next-state and output computation for the port sequencer
    always_comb begin
        state_d       = state_q;
        gnt0_d        = gnt0_q;
        gnt1_d        = gnt1_q;
        done0_d       = done0_q;
        done1_d       = done1_q;
        sel_d         = sel_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_we_d      = mem_we_q;
        rdata_d       = rdata_q;
        count_d       = count_q;
        last_served_d = last_served_q;
        // On a tie the requester that was not served last wins
        win_s         = (req0 && req1) ? ~last_served_q : req1;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d       = BUSY;
                    gnt0_d        = ~win_s;
                    gnt1_d        = win_s;
                    sel_d         = win_s;
                    mem_addr_d    = win_s ? addr1 : addr0;
                    mem_wdata_d   = win_s ? wdata1 : wdata0;
                    mem_we_d      = win_s ? we1 : we0;
                    count_d       = CNT_INIT;
                    last_served_d = win_s;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    rdata_d  = mem_rdata;
                    mem_we_d = 1'b0;
                    gnt0_d   = 1'b0;
                    gnt1_d   = 1'b0;
                    done0_d  = gnt0_q;
                    done1_d  = gnt1_q;
                    state_d  = DONE;
                end
            end
            DONE: begin
                done0_d = 1'b0;
                done1_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                gnt0_d   = 1'b0;
                gnt1_d   = 1'b0;
                done0_d  = 1'b0;
                done1_d  = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            sel_q         <= 1'b0;
            mem_addr_q    <= {WIDTH{1'b0}};
            mem_wdata_q   <= {WIDTH{1'b0}};
            mem_we_q      <= 1'b0;
            rdata_q       <= {WIDTH{1'b0}};
            count_q       <= 4'd0;
            last_served_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            sel_q         <= sel_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_we_q      <= mem_we_d;
            rdata_q       <= rdata_d;
            count_q       <= count_d;
            last_served_q <= last_served_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign sel       = sel_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign rdata     = rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the shared 16-bit memory port between two requesters: requester 0 is instruction fetch and requester 1 is data load/store.
- Owns the select line of the 16-bit 2:1 address/data mux in front of memory.
- Captures the winning request, holds the port for a fixed access latency, and returns read data with a one-cycle done pulse.
- Uses round-robin arbitration so neither requester starves.

Parameters:
- WIDTH, 16, data and address width in bits.
- LAT, 2, memory access cycles per transaction; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 access request.
- addr0  in  WIDTH  requester 0 address.
- wdata0  in  WIDTH  requester 0 write data.
- we0  in  1  requester 0 write enable (1 = write, 0 = read).
- req1  in  1  requester 1 access request.
- addr1  in  WIDTH  requester 1 address.
- wdata1  in  WIDTH  requester 1 write data.
- we1  in  1  requester 1 write enable.
- gnt0  out  1  requester 0 owns the port.
- gnt1  out  1  requester 1 owns the port.
- done0  out  1  one-cycle completion pulse for requester 0.
- done1  out  1  one-cycle completion pulse for requester 1.
- rdata  out  WIDTH  read data for the completing requester; valid during its done cycle.
- sel  out  1  mux select; 0 = requester 0, 1 = requester 1.
- mem_addr  out  WIDTH  registered address to memory.
- mem_wdata  out  WIDTH  registered write data to memory.
- mem_we  out  1  memory write enable.
- mem_rdata  in  WIDTH  memory read data.

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-high.
  - On reset: state = IDLE, gnt0/gnt1/done0/done1/mem_we = 0, sel = 0, mem_addr/mem_wdata/rdata = 0, count = 0, last_served = 1 (so requester 0 wins the first tie).
  - Reset takes priority over every other event.
- States: IDLE, BUSY, DONE.
- IDLE:
  - No requests: stay in IDLE.
  - Exactly one req: grant it.
  - Both req: grant the requester that is not last_served.
  - On the grant edge: gntX = 1, sel = X, capture addrX/wdataX/weX into mem_addr/mem_wdata/mem_we, count = LAT-1, last_served = X, go to BUSY.
  - Requester inputs are sampled only on this edge; the requester does not need to hold them afterwards.
- BUSY:
  - mem_we, mem_addr, mem_wdata, sel and gntX are held stable.
  - If count != 0: decrement count.
  - If count == 0: rdata <= mem_rdata (rdata is also updated on writes, and its value is don't-care for writes); mem_we <= 0; gntX <= 0; doneX <= 1; go to DONE.
- DONE:
  - doneX is high for exactly this cycle; the next edge clears it and returns to IDLE.
  - rdata keeps its value until the next completion.
  - Requests are not sampled in DONE.
- Requester protocol:
  - req is deasserted on the same edge that ends the requester's done cycle.
  - A req still high in the following IDLE cycle starts a new transaction.
- Latency: request first seen in IDLE at cycle t.
  - gnt is high in cycles t+1 .. t+LAT.
  - done is high in cycle t+LAT+1.
  - The earliest next grant is at the edge ending cycle t+LAT+2.
- Fairness: with both requesters requesting continuously, grants alternate 0,1,0,1,...
- Invariants:
  - gnt0 and gnt1 are never both high.
  - done0 and done1 are never both high.
  - At most one transaction is in flight.
- Reset mid-BUSY or mid-DONE: the transaction is aborted, no done pulse is issued, and mem_we is low from the cycle after the reset edge.
- req changes during BUSY or DONE are ignored. A req that drops before being granted is never serviced.

Test Plan:
- Read, requester 0 only: LAT=2, memory model returns 16'h00AB at 16'h0010, req0=1 with addr0=16'h0010 and we0=0 → sel=0, gnt0 high for 2 cycles, done0 pulse for 1 cycle with rdata=16'h00AB, gnt1 and done1 stay 0.
- Write, requester 1 only: addr1=16'h0020, wdata1=16'h1234, we1=1 → sel=1, mem_we=1 for exactly LAT cycles with mem_addr=16'h0020 and mem_wdata=16'h1234, then done1 pulse; a following read of 16'h0020 returns 16'h1234.
- Simultaneous requests right after reset: req0 and req1 rise in the same cycle → requester 0 is served first, then requester 1, with done0 preceding done1 by LAT+2 cycles.
- Continuous contention: req0 and req1 held high (each re-asserting after its done) for 8 transactions → grant sequence 0,1,0,1,0,1,0,1; no overlapping gnt or done.
- Reset mid-operation: reset asserted during the second BUSY cycle of a write → next cycle gnt0=gnt1=0 and mem_we=0, no done pulse, state IDLE; a subsequent tie goes to requester 0.
- LAT=1 build: single read → gnt high for 1 cycle, done in the next cycle, rdata correct.
